// File: rtl/plotter_pkg.sv
// Shared definitions for the plotter step generators: per-axis state encoding,
// default timing parameters and the step-period clamp.
package plotter_pkg;

  localparam int unsigned PulseWDefault    = 200;
  localparam int unsigned DirSetupDefault  = 500;
  localparam int unsigned MinPeriodDefault = 1000;

  typedef enum logic [1:0] {
    StIdle,
    StDirSetup,
    StStepHigh,
    StStepLow
  } axis_state_e;

  // Requested periods shorter than the driver minimum are stretched, never rejected.
  function automatic logic [31:0] clamp_period(input logic [31:0] speed,
                                               input logic [31:0] min_period);
    return (speed < min_period) ? min_period : speed;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable 32-bit down-counter; done is high while the count sits at zero, so a
// load of N-1 gives a phase that lasts exactly N cycles.
module cycle_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic        done
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/axis_step_gen.sv
// Step/direction pulse generator for one plotter axis, driven by the processor's
// speed (period in cycles) and direction registers; tracks a signed position.
module axis_step_gen
  import plotter_pkg::*;
#(
  parameter int unsigned PULSE_W    = PulseWDefault,
  parameter int unsigned DIR_SETUP  = DirSetupDefault,
  parameter int unsigned MIN_PERIOD = MinPeriodDefault
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] speed,
  input  logic [31:0] dir,
  input  logic        home,
  output logic        pin_step,
  output logic        pin_dir,
  output logic [31:0] position,
  output logic        busy
);

  localparam logic [31:0] PulseW    = 32'(PULSE_W);
  localparam logic [31:0] DirSetup  = 32'(DIR_SETUP);
  localparam logic [31:0] MinPeriod = 32'(MIN_PERIOD);

  axis_state_e state_q, state_d;
  logic        pin_step_q;
  logic        pin_dir_q, pin_dir_d;
  logic [31:0] position_q, position_d;
  logic [31:0] period_q, period_d;

  logic        dir_req;
  logic        decide;
  logic        step_start;
  logic        timer_load;
  logic [31:0] timer_value;
  logic        timer_done;

  assign dir_req = (dir != '0);

  cycle_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    pin_dir_d   = pin_dir_q;
    period_d    = period_q;
    decide      = 1'b0;
    step_start  = 1'b0;
    timer_load  = 1'b0;
    timer_value = '0;

    unique case (state_q)
      StIdle: begin
        decide = 1'b1;
      end
      StDirSetup: begin
        if (timer_done) begin
          if (speed != '0) begin
            step_start = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StStepHigh: begin
        if (timer_done) begin
          state_d     = StStepLow;
          timer_load  = 1'b1;
          timer_value = period_q - PulseW - 32'd1;
        end
      end
      StStepLow: begin
        decide = timer_done;
      end
    endcase

    if (decide) begin
      if (speed == '0) begin
        state_d = StIdle;
      end else if (dir_req != pin_dir_q) begin
        // Direction flips only here, so the driver always sees a full setup time.
        state_d     = StDirSetup;
        pin_dir_d   = dir_req;
        timer_load  = 1'b1;
        timer_value = DirSetup - 32'd1;
      end else begin
        step_start = 1'b1;
      end
    end

    if (step_start) begin
      state_d     = StStepHigh;
      period_d    = clamp_period(speed, MinPeriod);
      timer_load  = 1'b1;
      timer_value = PulseW - 32'd1;
    end
  end

  always_comb begin
    position_d = position_q;
    if (step_start) begin
      position_d = pin_dir_q ? (position_q - 32'd1) : (position_q + 32'd1);
    end
    if (home) begin
      position_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      pin_step_q <= 1'b0;
      pin_dir_q  <= 1'b0;
      position_q <= '0;
      period_q   <= '0;
    end else begin
      state_q    <= state_d;
      pin_step_q <= (state_d == StStepHigh);
      pin_dir_q  <= pin_dir_d;
      position_q <= position_d;
      period_q   <= period_d;
    end
  end

  assign pin_step = pin_step_q;
  assign pin_dir  = pin_dir_q;
  assign position = position_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_axis_step_gen.sv
// Scoreboard bench for axis_step_gen: a timestamp-level reference model predicts
// step rises, pulse ends and busy drops; a monitor matches them against the pins.
module tb_axis_step_gen;

  localparam int unsigned PW = 2;
  localparam int unsigned DS = 3;
  localparam int unsigned MP = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] speed = '0;
  logic [31:0] dir   = '0;
  logic        home  = 1'b0;
  logic        pin_step, pin_dir, busy;
  logic [31:0] position;

  axis_step_gen #(
    .PULSE_W    (PW),
    .DIR_SETUP  (DS),
    .MIN_PERIOD (MP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .speed    (speed),
    .dir      (dir),
    .home     (home),
    .pin_step (pin_step),
    .pin_dir  (pin_dir),
    .position (position),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: works on edge numbers, not on states.
  typedef struct {
    int unsigned at;
    logic [31:0] pos;
    bit          d;
  } rise_t;

  int unsigned edge_n   = 0;
  bit          m_active = 1'b0;
  bit          m_setup  = 1'b0;
  bit          m_dir    = 1'b0;
  int unsigned m_next   = 0;
  logic [31:0] m_pos    = '0;
  rise_t       rise_q[$];
  int unsigned fall_q[$];
  int unsigned idle_q[$];

  always @(posedge clock) begin : model
    bit          rise;
    bit          stop;
    int unsigned per;
    edge_n++;
    rise = 1'b0;
    stop = 1'b0;
    if (reset) begin
      if (m_active) idle_q.push_back(edge_n);
      if (fall_q.size() > 0 && fall_q[fall_q.size()-1] > edge_n) begin
        fall_q[fall_q.size()-1] = edge_n;
      end
      m_active = 1'b0;
      m_setup  = 1'b0;
      m_dir    = 1'b0;
      m_pos    = '0;
    end else begin
      if (!m_active || edge_n == m_next) begin
        if (m_setup) begin
          m_setup = 1'b0;
          if (speed != 0) rise = 1'b1;
          else stop = 1'b1;
        end else if (speed == 0) begin
          stop = 1'b1;
        end else if ((dir != 0) != m_dir) begin
          m_dir    = (dir != 0);
          m_setup  = 1'b1;
          m_active = 1'b1;
          m_next   = edge_n + DS;
        end else begin
          rise = 1'b1;
        end
      end
      if (stop && m_active) idle_q.push_back(edge_n);
      if (stop) m_active = 1'b0;
      if (rise) begin
        per      = (speed < MP) ? MP : speed;
        m_active = 1'b1;
        m_next   = edge_n + per;
        m_pos    = m_dir ? m_pos - 32'd1 : m_pos + 32'd1;
      end
      if (home) m_pos = '0;
      if (rise) begin
        rise_q.push_back('{edge_n, m_pos, m_dir});
        fall_q.push_back(edge_n + PW);
      end
    end
  end

  bit          prev_step = 1'b0;
  bit          prev_busy = 1'b0;
  int unsigned last_idle = 0;
  int unsigned rise_log[$];

  always @(negedge clock) begin : monitor
    rise_t       exp_r;
    int unsigned exp_e;
    if (edge_n > 0) begin
      if (pin_step && !prev_step) begin
        rise_log.push_back(edge_n);
        if (rise_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL step_rise: pulse at edge %0d, required none", edge_n);
        end else begin
          exp_r = rise_q.pop_front();
          check("rise_edge", edge_n, exp_r.at);
          check("rise_position", position, exp_r.pos);
          check("rise_pin_dir", 32'(pin_dir), 32'(exp_r.d));
        end
      end
      if (!pin_step && prev_step) begin
        if (fall_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL step_fall: fall at edge %0d, required none", edge_n);
        end else begin
          exp_e = fall_q.pop_front();
          check("fall_edge", edge_n, exp_e);
        end
      end
      if (!busy && prev_busy) begin
        last_idle = edge_n;
        if (idle_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL busy_drop: drop at edge %0d, required none", edge_n);
        end else begin
          exp_e = idle_q.pop_front();
          check("busy_drop_edge", edge_n, exp_e);
        end
      end
    end
    prev_step = pin_step;
    prev_busy = busy;
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic wait_rises(input int unsigned n, input int unsigned limit, input string name);
    int unsigned k;
    k = 0;
    while (rise_log.size() < n && k < limit) begin
      tick(1);
      k++;
    end
    check(name, 32'(rise_log.size() >= n), 32'd1);
  endtask

  initial begin : stimulus
    int unsigned prev_rise;
    int unsigned r;

    reset = 1'b1;
    tick(3);
    check("reset_pin_step", 32'(pin_step), 32'd0);
    check("reset_pin_dir", 32'(pin_dir), 32'd0);
    check("reset_position", position, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // Steady run at period 10.
    rise_log.delete();
    speed = 10;
    dir   = 0;
    tick(1);
    check("first_rise_latency", 32'(pin_step), 32'd1);
    tick(49);
    check("run_rise_count", rise_log.size(), 32'd5);
    check("run_spacing", rise_log[4] - rise_log[3], 32'd10);
    check("run_position", position, 32'd5);
    check("run_pin_dir", 32'(pin_dir), 32'd0);
    speed = 0;
    tick(12);

    // Period clamp.
    rise_log.delete();
    speed = 1;
    tick(13);
    check("clamp_rise_count", rise_log.size(), 32'd4);
    check("clamp_spacing", rise_log[1] - rise_log[0], 32'd4);
    speed = 0;
    tick(6);

    // Direction reversal mid-run (position is 9 here).
    rise_log.delete();
    speed = 10;
    dir   = 0;
    tick(15);
    dir       = 1;
    prev_rise = rise_log[rise_log.size()-1];
    rise_log.delete();
    tick(1);
    check("dir_held_mid_period", 32'(pin_dir), 32'd0);
    wait_rises(1, 30, "dir_change_rise_timeout");
    check("dir_change_gap", rise_log[0] - prev_rise, 32'd13);
    check("dir_change_pin_dir", 32'(pin_dir), 32'd1);
    check("dir_change_position", position, 32'd10);
    speed = 0;
    tick(15);

    // Stop requested during the high phase.
    rise_log.delete();
    speed = 10;
    wait_rises(1, 20, "stop_rise_timeout");
    speed = 0;
    tick(15);
    check("stop_rise_count", rise_log.size(), 32'd1);
    check("stop_busy_delay", last_idle - rise_log[0], 32'd10);

    // Home, home colliding with a step, and wrap below zero.
    home = 1'b1;
    tick(1);
    home = 1'b0;
    check("home_clear", position, 32'd0);
    rise_log.delete();
    dir   = 0;
    speed = 4;
    wait_rises(6, 60, "home_rise_timeout");
    check("pre_home_position", position, 32'd6);
    tick(3);
    home = 1'b1;
    tick(1);
    home = 1'b0;
    check("home_over_step", position, 32'd0);
    check("home_keeps_step", 32'(pin_step), 32'd1);
    speed = 0;
    dir   = 1;
    tick(8);
    rise_log.delete();
    speed = 4;
    wait_rises(1, 20, "wrap_rise_timeout");
    speed = 0;
    check("wrap_position", position, 32'hFFFF_FFFF);
    tick(8);

    // Reset during a high phase, then a clean restart.
    rise_log.delete();
    dir   = 0;
    speed = 10;
    wait_rises(2, 40, "reset_rise_timeout");
    reset = 1'b1;
    tick(1);
    check("midstep_reset_pin_step", 32'(pin_step), 32'd0);
    check("midstep_reset_position", position, 32'd0);
    check("midstep_reset_busy", 32'(busy), 32'd0);
    check("midstep_reset_pin_dir", 32'(pin_dir), 32'd0);
    reset = 1'b0;
    rise_log.delete();
    tick(25);
    check("restart_rise_count", rise_log.size(), 32'd3);
    check("restart_position", position, 32'd3);

    // Randomised traffic.
    for (int s = 0; s < 150; s++) begin
      r     = $urandom_range(0, 99);
      speed = (r < 20) ? 32'd0 : 32'($urandom_range(1, 30));
      dir   = ($urandom_range(0, 1) == 1) ? $urandom : 32'd0;
      home  = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 39) == 0);
      tick(reset ? $urandom_range(1, 3) : 1);
      home  = 1'b0;
      reset = 1'b0;
      tick($urandom_range(1, 40));
    end

    speed = 0;
    tick(40);
    check("final_rise_queue_empty", rise_q.size(), 32'd0);
    check("final_fall_queue_empty", fall_q.size(), 32'd0);
    check("final_idle_queue_empty", idle_q.size(), 32'd0);
    check("final_position", position, m_pos);
    check("final_pin_dir", 32'(pin_dir), 32'(m_dir));
    check("final_busy", 32'(busy), 32'(m_active));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_step_gen.md
AXIS_STEP_GEN -- requirements
Module: axis_step_gen

Interface
REQ-001 Parameter PULSE_W, default 200, sets the step-high width in clock cycles (2 us at 100 MHz).
REQ-002 Parameter DIR_SETUP, default 500, sets the cycles between a pin_dir change and the next step rising edge.
REQ-003 Parameter MIN_PERIOD, default 1000, sets the minimum step period in cycles; legal only if MIN_PERIOD >= 2*PULSE_W.
REQ-004 Port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port speed, input, 32 bits: requested step period in cycles (unsigned); 0 means stop.
REQ-007 Port dir, input, 32 bits: direction request; nonzero means negative (left/up), 0 means positive.
REQ-008 Port home, input, 1 bit: synchronous clear of the position counter.
REQ-009 Port pin_step, output, 1 bit: registered step pulse to the motor driver.
REQ-010 Port pin_dir, output, 1 bit: registered direction pin; 1 means negative.
REQ-011 Port position, output, 32 bits: signed two's-complement step count.
REQ-012 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The state machine SHALL have four states: IDLE, DIR_SETUP, STEP_HIGH and STEP_LOW.
REQ-014 Decision point (in IDLE, or on the last STEP_LOW cycle):
- speed==0 -> IDLE.
- dir_req (dir!=0) differs from pin_dir -> DIR_SETUP.
- otherwise -> STEP_HIGH.
REQ-015 pin_dir SHALL take dir_req on entry to DIR_SETUP and SHALL change at no other time.
REQ-016 DIR_SETUP SHALL last exactly DIR_SETUP cycles, then go to STEP_HIGH if speed!=0, else to IDLE.
REQ-017 On entry to STEP_HIGH, the step period SHALL be latched as max(speed, MIN_PERIOD); speed changes take effect only at the next entry.
REQ-018 STEP_HIGH SHALL last PULSE_W cycles; STEP_LOW SHALL last (latched period - PULSE_W) cycles.
REQ-019 pin_step SHALL be high exactly while in STEP_HIGH; it rises one cycle after the cycle in which IDLE sees speed!=0 with matching direction.
REQ-020 position SHALL change by -1 (pin_dir=1) or +1 (pin_dir=0) in the same cycle pin_step rises.
REQ-021 position SHALL wrap modulo 2^32 (0 minus 1 gives 0xFFFFFFFF).
REQ-022 speed falling to 0 mid-step SHALL NOT truncate the pulse or the period: the full period completes, then the block returns to IDLE.
REQ-023 home SHALL set position to 0 the next cycle; home SHALL override a simultaneous step increment or decrement.
REQ-024 home SHALL NOT affect the state, pin_step or pin_dir.

Reset
REQ-025 On reset, the next cycle SHALL give:
- state IDLE;
- pin_step=0, pin_dir=0, position=0, busy=0;
- all counters 0.
REQ-026 Reset SHALL override all other inputs, including home and a STEP_HIGH in progress.

Structure
REQ-027 A shared package plotter_pkg SHALL hold the state enum and the default values of PULSE_W, DIR_SETUP and MIN_PERIOD.
REQ-028 One sub-module, cycle_timer, SHALL provide a loadable 32-bit down-counter with a done flag for the DIR_SETUP, STEP_HIGH and STEP_LOW durations.
REQ-029 One instance per axis; the top level instantiates it twice (x, y) from the processor's speed/direction registers.

Verification (bench overrides PULSE_W=2, DIR_SETUP=3, MIN_PERIOD=4)
REQ-030 Reset, then speed=10, dir=0 for 50 cycles:
- pin_step rises 1 cycle after speed is applied;
- each pulse is 2 cycles high, with a rising edge every 10 cycles;
- position reaches 5; pin_dir stays 0.
REQ-031 speed=1, dir=0: the period is clamped, with rising edges 4 cycles apart.
REQ-032 Running at speed=10 with dir=0, set dir=1:
- the current period completes, then pin_dir=1;
- the next rising edge is 3 cycles later;
- position decrements from that edge on.
REQ-033 speed set to 0 during STEP_HIGH: the pulse stays 2 cycles wide, busy drops 10 cycles after the rise, and no further pulses occur.
REQ-034 home asserted in the cycle pin_step rises at position 7: the next-cycle position is 0. From position 0 with dir=1, one step gives 0xFFFFFFFF.
REQ-035 reset asserted during STEP_HIGH: the next cycle gives pin_step=0, position=0, busy=0, and stepping restarts cleanly once reset is released.
